// File: rtl/bip_debug_ctrl.sv
// bip_debug_ctrl
// Run/step/dump controller for the BIP core. Decodes single-byte UART commands,
// gates the BIP with a clock enable, issues soft resets, counts executed cycles
// and streams a PC/ACC/cycle-count snapshot out through a valid/ready byte port.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_rx_data, i_rx_valid command byte and its one-cycle strobe
//   o_tx_data, o_tx_valid dump byte stream (valid/ready)
//   i_tx_ready            sink accepts the byte when valid && ready
//   o_bip_en              BIP clock enable, one instruction per high cycle
//   o_bip_rst             one-cycle synchronous soft reset to the BIP
//   i_pc, i_acc, i_inst   BIP program counter, accumulator, current instruction
//   o_busy                high whenever the controller is not idle
module bip_debug_ctrl #(
    parameter int unsigned NB_BITS   = 16,
    parameter int unsigned NB_PC     = 11,
    parameter int unsigned NB_OPCODE = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_bip_en,
    output logic               o_bip_rst,
    input  logic [NB_PC-1:0]   i_pc,
    input  logic [NB_BITS-1:0] i_acc,
    input  logic [NB_BITS-1:0] i_inst,
    output logic               o_busy
);

    localparam logic [7:0] CMD_RUN   = 8'h52; // 'R'
    localparam logic [7:0] CMD_STEP  = 8'h53; // 'S'
    localparam logic [7:0] CMD_DUMP  = 8'h44; // 'D'
    localparam logic [7:0] CMD_SRST  = 8'h58; // 'X'
    localparam logic [7:0] CMD_BREAK = 8'h42; // 'B'

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StDump,
        StSrst
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] cyc_snap_q;
    logic [7:0]  pc_lo_q;
    logic [15:0] acc_snap_q;
    logic [2:0]  idx_q, idx_d;

    logic [15:0] pc_ext;
    logic        is_halt;
    logic        is_break;
    logic        bip_en;
    logic        bip_rst;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        unused_inst;

    assign pc_ext      = 16'(i_pc);
    assign is_halt     = (i_inst[NB_BITS-1 -: NB_OPCODE] == '0);
    assign is_break    = i_rx_valid && (i_rx_data == CMD_BREAK);
    assign unused_inst = ^i_inst[NB_BITS-NB_OPCODE-1:0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bip_en   = 1'b0;
        bip_rst  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_RUN:  state_d = StRun;
                        CMD_STEP: state_d = StStep;
                        CMD_DUMP: state_d = StDump;
                        CMD_SRST: state_d = StSrst;
                        default:  state_d = StIdle;
                    endcase
                end
            end
            StRun: begin
                // HALT and break in the same cycle collapse into one transition.
                if (is_halt || is_break) begin
                    state_d = StDump;
                end else begin
                    bip_en = 1'b1;
                end
            end
            StStep: begin
                bip_en  = !is_halt;
                state_d = StDump;
            end
            StDump: begin
                tx_valid = 1'b1;
                // The BIP is stalled for the whole dump, so its live PC/ACC already
                // reflect the last executed instruction; byte 0 reads them directly
                // and the registers hold them for the remaining bytes.
                case (idx_q)
                    3'd0:    tx_data = pc_ext[15:8];
                    3'd1:    tx_data = pc_lo_q;
                    3'd2:    tx_data = acc_snap_q[15:8];
                    3'd3:    tx_data = acc_snap_q[7:0];
                    3'd4:    tx_data = cyc_snap_q[15:8];
                    default: tx_data = cyc_snap_q[7:0];
                endcase
                if (i_tx_ready) begin
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StSrst: begin
                bip_rst = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating count of enabled cycles; soft reset clears it.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == StSrst) begin
            cyc_d = 16'h0000;
        end else if (bip_en && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'h0001;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cyc_q      <= 16'h0000;
            cyc_snap_q <= 16'h0000;
            pc_lo_q    <= 8'h00;
            acc_snap_q <= 16'h0000;
            idx_q      <= 3'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            // cyc_d already includes the final enabled cycle.
            if ((state_d == StDump) && (state_q != StDump)) begin
                cyc_snap_q <= cyc_d;
            end
            if ((state_q == StDump) && (idx_q == 3'd0)) begin
                pc_lo_q    <= pc_ext[7:0];
                acc_snap_q <= 16'(i_acc);
            end
        end
    end

    assign o_bip_en   = bip_en;
    assign o_bip_rst  = bip_rst;
    assign o_tx_valid = tx_valid;
    assign o_tx_data  = tx_data;
    assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Directed bench for bip_debug_ctrl with a small BIP stub
// (PC +1 per enabled cycle, HALT at PC 5 when enabled, ACC fixed at 0xAABB).
module tb_bip_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bip_en;
    logic        bip_rst;
    logic [10:0] pc;
    logic [15:0] acc;
    logic [15:0] inst;
    logic        busy;

    logic        halt_en;
    logic        en_clr;
    int          en_cnt;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [47:0] dword;
    int          nb;

    always #5 clk = ~clk;

    bip_debug_ctrl #(
        .NB_BITS  (16),
        .NB_PC    (11),
        .NB_OPCODE(5)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rx_data (rx_data),
        .i_rx_valid(rx_valid),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_bip_en  (bip_en),
        .o_bip_rst (bip_rst),
        .i_pc      (pc),
        .i_acc     (acc),
        .i_inst    (inst),
        .o_busy    (busy)
    );

    // BIP stub
    always @(posedge clk or posedge rst) begin
        if (rst)          pc <= '0;
        else if (bip_rst) pc <= '0;
        else if (bip_en)  pc <= pc + 11'd1;
    end
    assign acc  = 16'hAABB;
    assign inst = (halt_en && (pc == 11'd5)) ? 16'h0000 : 16'h0800;

    always @(posedge clk) begin
        if (en_clr)      en_cnt <= 0;
        else if (bip_en) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        en_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        en_clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Collects six accepted bytes into dword; optional 1-0-0-1 ready pattern and
    // an 'R' injected mid-dump.
    task automatic get_dump(input bit toggle, input bit inject_r);
        int         cyc    = 0;
        bit         held   = 1'b0;
        logic [7:0] held_b = 8'h00;
        nb    = 0;
        dword = '0;
        while (nb < 6 && cyc < 100) begin
            @(negedge clk);
            if (held) check("hold_byte", tx_data, held_b);
            tx_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (inject_r) begin
                rx_data  = 8'h52;
                rx_valid = (cyc == 2);
            end
            held = 1'b0;
            if (tx_valid) begin
                if (tx_ready) begin
                    dword = {dword[39:0], tx_data};
                    nb++;
                end else begin
                    held   = 1'b1;
                    held_b = tx_data;
                end
            end
            cyc++;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        if (nb != 6) check("dump_timeout", nb, 6);
    endtask

    initial begin
        rst      = 1'b1;
        en_clr   = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        halt_en  = 1'b1;
        #1;
        check("rst_en", bip_en, 0);
        check("rst_bip_rst", bip_rst, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        en_clr = 1'b0;

        // Unknown byte is ignored
        send_byte(8'h5A);
        check("ignore_busy", busy, 0);

        // Single step
        send_byte(8'h53);
        check("step_en", bip_en, 1);
        check("step_busy", busy, 1);
        get_dump(1'b0, 1'b0);
        check("step_dump", dword, 48'h0001_AABB_0001);
        @(negedge clk);
        check("step_idle", busy, 0);
        check("step_txv_idle", tx_valid, 0);
        check("step_en_cycles", en_cnt, 1);

        // Run to HALT
        do_reset();
        halt_en = 1'b1;
        send_byte(8'h52);
        check("run_en", bip_en, 1);
        for (int k = 0; k < 50 && pc != 11'd5; k++) @(negedge clk);
        check("run_halt_pc", pc, 5);
        check("run_halt_en", bip_en, 0);
        check("run_halt_txv", tx_valid, 0);
        get_dump(1'b0, 1'b0);
        check("run_dump", dword, 48'h0005_AABB_0005);
        check("run_en_cycles", en_cnt, 5);
        send_byte(8'h52);
        check("rerun_en", bip_en, 0);
        get_dump(1'b0, 1'b0);
        check("rerun_dump", dword, 48'h0005_AABB_0005);
        check("rerun_en_cycles", en_cnt, 5);

        // Run without HALT, break after 20 enabled cycles
        do_reset();
        halt_en = 1'b0;
        send_byte(8'h52);
        for (int k = 0; k < 100 && en_cnt != 20; k++) @(negedge clk);
        rx_data  = 8'h42;
        rx_valid = 1'b1;
        #1;
        check("break_en", bip_en, 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        get_dump(1'b0, 1'b0);
        check("break_dump", dword, 48'h0014_AABB_0014);
        check("break_en_cycles", en_cnt, 20);
        @(negedge clk);
        check("break_idle", busy, 0);

        // Dump with back-pressure and a dropped 'R'
        tx_ready = 1'b0;
        send_byte(8'h44);
        check("dump_busy", busy, 1);
        get_dump(1'b1, 1'b1);
        check("bp_dump", dword, 48'h0014_AABB_0014);
        @(negedge clk);
        check("bp_idle", busy, 0);
        check("bp_no_run", bip_en, 0);

        // Soft reset
        send_byte(8'h58);
        check("srst_pulse", bip_rst, 1);
        check("srst_txv", tx_valid, 0);
        @(negedge clk);
        check("srst_pulse_end", bip_rst, 0);
        check("srst_idle", busy, 0);
        check("srst_txv2", tx_valid, 0);
        tx_ready = 1'b0;
        send_byte(8'h44);
        get_dump(1'b0, 1'b0);
        check("srst_dump", dword, 48'h0000_AABB_0000);

        // Reset during byte 3 of a dump
        @(negedge clk);
        tx_ready = 1'b1;
        send_byte(8'h44);
        repeat (3) @(negedge clk);
        check("mid_byte3", tx_data, 8'hBB);
        rst = 1'b1;
        #1;
        check("mid_rst_txv", tx_valid, 0);
        check("mid_rst_txd", tx_data, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", bip_en, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_hold_busy", busy, 0);
        check("mid_hold_txv", tx_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
